alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, clocked successor to the 64-bit ripple ALU in the datapath.
- Width is configurable. Operands are captured through a valid/ready handshake; the result and flags are registered and held until consumed.
- Keeps the existing cntrl encoding and adds two operations: logical shift left (single cycle) and an iterative shift-add multiply (multi-cycle).
- Sits between the register-file read stage and writeback; the control unit issues ops and waits on out_valid.

Parameters:
WIDTH, 64, operand/result width in bits (>= 4, power of two)
SHAMT_W, $clog2(WIDTH), number of B low bits used as shift amount

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  operand/op presented
in_ready  out  1  block can accept (high only in IDLE)
A  in  WIDTH  operand A
B  in  WIDTH  operand B
cntrl  in  3  operation select
out_valid  out  1  result/flags valid, held until out_ready
out_ready  in  1  consumer accepts result
result  out  WIDTH  registered result
negative  out  1  result[WIDTH-1]
zero  out  1  result == 0
overflow  out  1  two's-complement overflow (ADD/SUB only)
carry_out  out  1  carry out of MSB (ADD/SUB only)

Behaviour:
- Op encoding:
  - 000 PASS_B: result = B
  - 001 LSL: result = A << B[SHAMT_W-1:0]
  - 010 ADD: result = A + B
  - 011 SUB: result = A + ~B + 1
  - 100 AND: result = A & B
  - 101 OR: result = A | B
  - 110 XOR: result = A ^ B
  - 111 MUL: result = low WIDTH bits of unsigned A*B
- Reset (synchronous, reset high at a clock edge):
  - state = IDLE; result = 0; all four flags = 0; out_valid = 0.
  - Internal multiplicand, multiplier and counter are cleared.
  - Reset overrides everything, including a MUL in progress and a pending out_valid.
- States: IDLE, MUL, DONE.
- Handshake:
  - Accept occurs when in_valid && in_ready. in_ready = (state == IDLE).
  - A, B and cntrl are sampled only at accept; changes afterwards are ignored.
- IDLE, accept with op != 111:
  - Compute combinationally and register result and flags at the same edge; go to DONE.
  - out_valid is high the cycle after accept (latency 1).
- IDLE, accept with op == 111:
  - Capture mcand = A, mplier = B; clear acc and cnt; go to MUL.
- MUL, each cycle:
  - If mplier[0], acc += mcand (mod 2^WIDTH).
  - mcand <<= 1; mplier >>= 1; cnt++.
  - When cnt == WIDTH-1 (the WIDTH-th iteration), load result with the final acc and go to DONE.
  - Fixed latency: out_valid rises WIDTH+1 cycles after accept. There is no early exit.
- DONE:
  - out_valid = 1; result and flags stay stable.
  - If out_ready, go to IDLE (out_valid low next cycle).
  - If out_ready is already high when DONE is entered, the hand-off still takes one cycle in DONE.
- Flags:
  - negative = result[WIDTH-1]; zero = (result == 0). Both apply to all ops.
  - ADD/SUB: carry_out = carry out of bit WIDTH-1; overflow = carry into MSB XOR carry out of MSB.
  - SUB carry_out follows the A + ~B + 1 convention: 1 means no borrow.
  - All other ops, including LSL and MUL: overflow = 0, carry_out = 0.
- Flags and result update only on the transition into DONE; they are never modified in IDLE or MUL.
- Back-to-back throughput is one op per 2 cycles minimum (IDLE -> DONE -> IDLE).
- in_valid while busy (MUL or DONE) is ignored; the producer must hold until in_ready.
- LSL with shift amount 0 returns A. Only the low SHAMT_W bits of B are used; upper bits of B are ignored.

Test Plan:
1. WIDTH=64, ADD, A=B=64'h8000000000000000 -> one cycle after accept: out_valid=1, result=0, carry_out=1, overflow=1, zero=1, negative=0.
2. WIDTH=64, SUB:
   - A=1, B=1 -> result=0, carry_out=1, overflow=0, zero=1.
   - A=64'h8000000000000000, B=1 -> result=64'h7FFFFFFFFFFFFFFF, overflow=1, carry_out=1.
3. WIDTH=64, MUL, A=64'd123456789, B=64'd1000 -> out_valid exactly 65 cycles after accept, result=64'd123456789000, overflow=0, carry_out=0; in_ready=0 throughout.
4. WIDTH=8, MUL, A=8'hFF, B=8'h02 -> result=8'hFE, negative=1, out_valid 9 cycles after accept.
   - WIDTH=8, LSL, A=8'h81, B=8'h09 (shamt=1) -> result=8'h02, carry_out=0.
5. Hold out_ready=0 for 10 cycles after a PASS_B (B=64'h5) -> result/out_valid stay stable and in_ready stays 0; raise out_ready -> IDLE next cycle, next op accepted.
6. Assert reset for one cycle at cycle 20 of a WIDTH=64 MUL -> next cycle: state IDLE, in_ready=1, out_valid=0, result=0, all flags 0; a following AND A=64'hF0F0, B=64'hFF00 gives 64'hF000.

Source files
------------

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operand/result handshake bundle for alu_seq
interface alu_seq_if #(
   parameter int WIDTH = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [2:0]       cntrl;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             negative;
   logic             zero;
   logic             overflow;
   logic             carry_out;

   modport master (
      output in_valid, A, B, cntrl, out_ready,
      input  in_ready, out_valid, result, negative, zero, overflow, carry_out
   );

   modport slave (
      input  in_valid, A, B, cntrl, out_ready,
      output in_ready, out_valid, result, negative, zero, overflow, carry_out
   );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with handshake, LSL and iterative shift-add multiply
module alu_seq #(
   parameter int WIDTH   = 64,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input logic     clk,
   input logic     reset,
   alu_seq_if.slave bus
);
   localparam logic [2:0] OP_PASS = 3'b000;
   localparam logic [2:0] OP_LSL  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_XOR  = 3'b110;
   localparam logic [2:0] OP_MUL  = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               neg_q, neg_d;
   logic               zero_q, zero_d;
   logic               ovf_q, ovf_d;
   logic               cout_q, cout_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;

   logic [WIDTH-1:0]   b_op;
   logic               is_sub;
   logic [WIDTH:0]     sum_w;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_ovf;
   logic               alu_cout;
   logic [WIDTH-1:0]   acc_sum;
   logic               accept;

   assign accept = bus.in_valid && (state_q == ST_IDLE);

   // SUB reuses the adder as A + ~B + 1, so carry_out=1 means no borrow
   always_comb begin
      is_sub   = (bus.cntrl == OP_SUB);
      b_op     = is_sub ? ~bus.B : bus.B;
      sum_w    = {1'b0, bus.A} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
      alu_res  = '0;
      alu_ovf  = 1'b0;
      alu_cout = 1'b0;
      case (bus.cntrl)
         OP_PASS: alu_res = bus.B;
         OP_LSL:  alu_res = bus.A << bus.B[SHAMT_W-1:0];
         OP_ADD, OP_SUB: begin
            alu_res  = sum_w[WIDTH-1:0];
            alu_cout = sum_w[WIDTH];
            alu_ovf  = (bus.A[WIDTH-1] == b_op[WIDTH-1]) &&
                       (sum_w[WIDTH-1] != bus.A[WIDTH-1]);
         end
         OP_AND:  alu_res = bus.A & bus.B;
         OP_OR:   alu_res = bus.A | bus.B;
         OP_XOR:  alu_res = bus.A ^ bus.B;
         default: alu_res = '0;
      endcase
   end

   assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      neg_d    = neg_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;
      cout_d   = cout_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (bus.cntrl == OP_MUL) begin
                  mcand_d  = bus.A;
                  mplier_d = bus.B;
                  acc_d    = '0;
                  cnt_d    = '0;
                  state_d  = ST_MUL;
               end else begin
                  result_d = alu_res;
                  neg_d    = alu_res[WIDTH-1];
                  zero_d   = (alu_res == '0);
                  ovf_d    = alu_ovf;
                  cout_d   = alu_cout;
                  state_d  = ST_DONE;
               end
            end
         end
         ST_MUL: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            // Always runs all WIDTH iterations to keep latency fixed
            if (cnt_q == SHAMT_W'(WIDTH - 1)) begin
               result_d = acc_sum;
               neg_d    = acc_sum[WIDTH-1];
               zero_d   = (acc_sum == '0);
               ovf_d    = 1'b0;
               cout_d   = 1'b0;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         neg_q    <= 1'b0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
         cout_q   <= 1'b0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         neg_q    <= neg_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
         cout_q   <= cout_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.result    = result_q;
   assign bus.negative  = neg_q;
   assign bus.zero      = zero_q;
   assign bus.overflow  = ovf_q;
   assign bus.carry_out = cout_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq at WIDTH=64 and WIDTH=8
module tb_alu_seq;
   logic clk = 1'b0;
   logic reset64 = 1'b1;
   logic reset8 = 1'b1;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   alu_seq_if #(.WIDTH(64)) if64();
   alu_seq_if #(.WIDTH(8))  if8();

   alu_seq #(.WIDTH(64)) dut64 (.clk(clk), .reset(reset64), .bus(if64));
   alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset8),  .bus(if8));

   typedef struct {
      int          w;
      logic [2:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] res;
      logic        n, z, v, c;
      int          lat;
   } vec_t;

   typedef struct packed {
      logic [63:0] res;
      logic        n, z, v, c;
   } exp_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Arithmetic reference: wide integer maths and signed range test for overflow
   function automatic exp_t model(input int w, input logic [2:0] op,
                                  input logic [63:0] a_in, input logic [63:0] b_in);
      logic [127:0]        mask, a, b, full;
      logic signed [127:0] sa, sb, ssum, hi, lo;
      exp_t e;
      mask = (128'd1 << w) - 128'd1;
      a = {64'd0, a_in} & mask;
      b = {64'd0, b_in} & mask;
      sa = a;
      sb = b;
      if (a[w-1]) sa = a - (128'd1 << w);
      if (b[w-1]) sb = b - (128'd1 << w);
      hi = (128'sd1 <<< (w - 1)) - 128'sd1;
      lo = -(128'sd1 <<< (w - 1));
      e.v = 1'b0;
      e.c = 1'b0;
      full = '0;
      ssum = '0;
      case (op)
         3'd0: full = b;
         3'd1: full = a << (b % w);
         3'd2: begin full = a + b; e.c = full[w]; ssum = sa + sb; e.v = (ssum > hi) || (ssum < lo); end
         3'd3: begin full = a + (~b & mask) + 128'd1; e.c = full[w]; ssum = sa - sb; e.v = (ssum > hi) || (ssum < lo); end
         3'd4: full = a & b;
         3'd5: full = a | b;
         3'd6: full = a ^ b;
         default: full = a * b;
      endcase
      full = full & mask;
      e.res = full[63:0];
      e.n = full[w-1];
      e.z = (full == 128'd0);
      return e;
   endfunction

   task automatic set_in(input int w, input logic v, input logic [2:0] op,
                         input logic [63:0] a, input logic [63:0] b);
      if (w == 64) begin
         if64.in_valid = v; if64.cntrl = op; if64.A = a; if64.B = b;
      end else begin
         if8.in_valid = v; if8.cntrl = op; if8.A = a[7:0]; if8.B = b[7:0];
      end
   endtask

   task automatic set_ready(input int w, input logic r);
      if (w == 64) if64.out_ready = r;
      else         if8.out_ready = r;
   endtask

   task automatic get_out(input int w, output logic ov, output logic ir, output logic [63:0] r,
                          output logic n, output logic z, output logic v, output logic c);
      if (w == 64) begin
         ov = if64.out_valid; ir = if64.in_ready; r = if64.result;
         n = if64.negative; z = if64.zero; v = if64.overflow; c = if64.carry_out;
      end else begin
         ov = if8.out_valid; ir = if8.in_ready; r = {56'd0, if8.result};
         n = if8.negative; z = if8.zero; v = if8.overflow; c = if8.carry_out;
      end
   endtask

   // Issue one op, keep garbage on the inputs while busy, measure latency, then hand off
   task automatic run_op(input int w, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input int hold, output logic [63:0] r, output logic n, output logic z,
                         output logic v, output logic c, output int lat);
      logic ov, ir, busy_bad;
      int   guard;
      guard = 0;
      get_out(w, ov, ir, r, n, z, v, c);
      while (!ir && guard < 10) begin
         @(posedge clk); #1;
         guard++;
         get_out(w, ov, ir, r, n, z, v, c);
      end
      chk("idle_before_issue", {63'd0, ir}, 64'd1);
      set_in(w, 1'b1, op, a, b);
      @(posedge clk); #1;
      set_in(w, 1'b1, 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
      lat = 1;
      busy_bad = 1'b0;
      get_out(w, ov, ir, r, n, z, v, c);
      while (!ov && lat < 300) begin
         if (ir) busy_bad = 1'b1;
         @(posedge clk); #1;
         lat++;
         get_out(w, ov, ir, r, n, z, v, c);
      end
      set_in(w, 1'b0, 3'd0, 64'd0, 64'd0);
      chk("busy_in_ready_low", {63'd0, busy_bad}, 64'd0);
      repeat (hold) begin @(posedge clk); #1; end
      set_ready(w, 1'b1);
      @(posedge clk); #1;
      set_ready(w, 1'b0);
   endtask

   vec_t        vecs[13];
   exp_t        e;
   logic [63:0] r;
   logic        n, z, v, c, ov, ir;
   int          lat;

   initial begin
      set_in(64, 1'b0, 3'd0, 64'd0, 64'd0);
      set_in(8, 1'b0, 3'd0, 64'd0, 64'd0);
      set_ready(64, 1'b0);
      set_ready(8, 1'b0);

      vecs[0]  = '{64, 3'd2, 64'h8000000000000000, 64'h8000000000000000, 64'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1};
      vecs[1]  = '{64, 3'd3, 64'd1, 64'd1, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1};
      vecs[2]  = '{64, 3'd3, 64'h8000000000000000, 64'd1, 64'h7FFFFFFFFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1};
      vecs[3]  = '{64, 3'd7, 64'd123456789, 64'd1000, 64'd123456789000, 1'b0, 1'b0, 1'b0, 1'b0, 65};
      vecs[4]  = '{8, 3'd7, 64'hFF, 64'h02, 64'hFE, 1'b1, 1'b0, 1'b0, 1'b0, 9};
      vecs[5]  = '{8, 3'd1, 64'h81, 64'h09, 64'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1};
      vecs[6]  = '{64, 3'd0, 64'hDEAD, 64'h5, 64'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1};
      vecs[7]  = '{64, 3'd4, 64'hF0F0, 64'hFF00, 64'hF000, 1'b0, 1'b0, 1'b0, 1'b0, 1};
      vecs[8]  = '{64, 3'd1, 64'h0123456789ABCDEF, 64'hFFFFFFFFFFFFFFC0, 64'h0123456789ABCDEF, 1'b0, 1'b0, 1'b0, 1'b0, 1};
      vecs[9]  = '{8, 3'd2, 64'h7F, 64'h01, 64'h80, 1'b1, 1'b0, 1'b1, 1'b0, 1};
      vecs[10] = '{8, 3'd3, 64'h00, 64'h01, 64'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1};
      vecs[11] = '{64, 3'd5, 64'hF0, 64'h0F, 64'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1};
      vecs[12] = '{8, 3'd7, 64'h10, 64'h10, 64'h00, 1'b0, 1'b1, 1'b0, 1'b0, 9};

      repeat (2) @(posedge clk);
      #1;
      get_out(64, ov, ir, r, n, z, v, c);
      chk("rst64_out_valid", {63'd0, ov}, 64'd0);
      chk("rst64_result", r, 64'd0);
      chk("rst64_flags", {60'd0, n, z, v, c}, 64'd0);
      get_out(8, ov, ir, r, n, z, v, c);
      chk("rst8_out_valid", {63'd0, ov}, 64'd0);
      chk("rst8_result", r, 64'd0);
      reset64 = 1'b0;
      reset8 = 1'b0;
      @(posedge clk); #1;
      get_out(64, ov, ir, r, n, z, v, c);
      chk("rst64_in_ready", {63'd0, ir}, 64'd1);

      for (int i = 0; i < 13; i++) begin
         run_op(vecs[i].w, vecs[i].op, vecs[i].a, vecs[i].b, i % 3, r, n, z, v, c, lat);
         chk($sformatf("vec%0d_result", i), r, vecs[i].res);
         chk($sformatf("vec%0d_flags_nzvc", i), {60'd0, n, z, v, c},
             {60'd0, vecs[i].n, vecs[i].z, vecs[i].v, vecs[i].c});
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      end

      // Stall: result held while out_ready stays low
      set_in(64, 1'b1, 3'd0, 64'd0, 64'h5);
      @(posedge clk); #1;
      set_in(64, 1'b0, 3'd0, 64'd0, 64'd0);
      for (int k = 0; k < 10; k++) begin
         get_out(64, ov, ir, r, n, z, v, c);
         chk($sformatf("stall%0d_hold", k), {r[61:0], ov, ir}, {62'h5, 1'b1, 1'b0});
         @(posedge clk); #1;
      end
      set_ready(64, 1'b1);
      @(posedge clk); #1;
      set_ready(64, 1'b0);
      get_out(64, ov, ir, r, n, z, v, c);
      chk("stall_release_idle", {62'd0, ov, ir}, {62'd0, 1'b0, 1'b1});
      run_op(64, 3'd6, 64'hFF00FF00, 64'h0FF00FF0, 0, r, n, z, v, c, lat);
      chk("after_stall_xor", r, 64'hF0F0F0F0);

      // out_ready already high when DONE is entered: one cycle of out_valid
      set_ready(64, 1'b1);
      set_in(64, 1'b1, 3'd0, 64'd0, 64'd9);
      @(posedge clk); #1;
      set_in(64, 1'b0, 3'd0, 64'd0, 64'd0);
      get_out(64, ov, ir, r, n, z, v, c);
      chk("early_ready_valid", {r[62:0], ov}, {63'd9, 1'b1});
      @(posedge clk); #1;
      get_out(64, ov, ir, r, n, z, v, c);
      chk("early_ready_handoff", {62'd0, ov, ir}, {62'd0, 1'b0, 1'b1});
      set_ready(64, 1'b0);

      // Reset mid-MUL aborts the multiply and clears result/flags
      set_in(64, 1'b1, 3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
      @(posedge clk); #1;
      set_in(64, 1'b0, 3'd0, 64'd0, 64'd0);
      repeat (19) @(posedge clk);
      #1;
      reset64 = 1'b1;
      @(posedge clk); #1;
      reset64 = 1'b0;
      get_out(64, ov, ir, r, n, z, v, c);
      chk("midmul_rst_hs", {62'd0, ov, ir}, {62'd0, 1'b0, 1'b1});
      chk("midmul_rst_result", r, 64'd0);
      chk("midmul_rst_flags", {60'd0, n, z, v, c}, 64'd0);
      run_op(64, 3'd4, 64'hF0F0, 64'hFF00, 0, r, n, z, v, c, lat);
      chk("midmul_rst_and", r, 64'hF000);
      chk("midmul_rst_and_lat", 64'(lat), 64'd1);

      for (int i = 0; i < 40; i++) begin
         int          w;
         logic [2:0]  op;
         logic [63:0] a, b;
         w  = ($urandom_range(0, 1) == 0) ? 8 : 64;
         op = 3'($urandom_range(0, 7));
         a  = {$urandom, $urandom};
         b  = (i % 4 == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
         e  = model(w, op, a, b);
         run_op(w, op, a, b, $urandom_range(0, 2), r, n, z, v, c, lat);
         chk($sformatf("rnd%0d_w%0d_op%0d_result", i, w, op), r, e.res);
         chk($sformatf("rnd%0d_flags_nzvc", i), {60'd0, n, z, v, c}, {60'd0, e.n, e.z, e.v, e.c});
         chk($sformatf("rnd%0d_latency", i), 64'(lat), (op == 3'd7) ? 64'(w + 1) : 64'd1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
